// File: rtl/topk_stream_sorter.sv
// topk_stream_sorter: keeps the K smallest distances from NUM_CH handshaked channels in a sorted shift register.
// Define TOPK_STORE_IDX_EN to store per-entry point indices; otherwise knn_idx reads all-ones.
module topk_stream_sorter #(
  parameter int K = 8,
  parameter int NUM_CH = 4,
  parameter int DIST_W = 32,
  parameter int IDX_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [K*DIST_W-1:0]      seed_dist,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH*DIST_W-1:0] ch_dist,
  input  logic [NUM_CH*IDX_W-1:0]  ch_idx,
  input  logic                     stream_end,
  output logic [DIST_W-1:0]        threshold,
  output logic [K*DIST_W-1:0]      knn_dist,
  output logic [K*IDX_W-1:0]       knn_idx,
  output logic                     done,
  output logic [CNT_W-1:0]         insert_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);
  localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_t;
  state_t state;
  logic [DIST_W-1:0] buf_d [K];
  logic [DIST_W-1:0] seed_srt [K];
  logic [DIST_W-1:0] ins_d [K];
  logic [DIST_W-1:0] slot_d [NUM_CH];
  logic [NUM_CH-1:0] slot_v, prune, cand;
  logic [PW-1:0] ptr, win;
  logic win_v;
  logic [DIST_W-1:0] win_d;
  logic [K:0] le;
  logic [CNT_W-1:0] drop_nxt;
  int rank [K];

  assign threshold = buf_d[K-1];
  assign ch_ready = state == RUN ? ~slot_v : '0;

  // stable rank: earlier equal seeds count against later ones, so equal seeds keep input order
  always_comb begin
    for (int i = 0; i < K; i++) begin
      rank[i] = 0;
      for (int j = 0; j < K; j++)
        if ((j < i) ? (seed_dist[j*DIST_W +: DIST_W] <= seed_dist[i*DIST_W +: DIST_W])
                    : (j > i && seed_dist[j*DIST_W +: DIST_W] < seed_dist[i*DIST_W +: DIST_W]))
          rank[i] = rank[i] + 1;
    end
    for (int r = 0; r < K; r++) begin
      seed_srt[r] = '0;
      for (int i = 0; i < K; i++)
        if (rank[i] == r) seed_srt[r] = seed_dist[i*DIST_W +: DIST_W];
    end
  end

  always_comb begin
    win_v = 1'b0;
    win = '0;
    for (int c = 0; c < NUM_CH; c++) prune[c] = slot_v[c] && slot_d[c] >= threshold;
    cand = slot_v & ~prune;
    for (int k = 0; k < NUM_CH; k++)
      if (!win_v && cand[(int'(ptr) + k) % NUM_CH]) begin
        win_v = 1'b1;
        win = PW'((int'(ptr) + k) % NUM_CH);
      end
    win_d = slot_d[win];
    // le is a prefix mask of entries <= winner; the winner lands just past it
    le[0] = 1'b1;
    for (int j = 0; j < K; j++) le[j+1] = buf_d[j] <= win_d;
    for (int j = 0; j < K; j++) ins_d[j] = le[j+1] ? buf_d[j] : le[j] ? win_d : buf_d[j > 0 ? j-1 : 0];
    drop_nxt = drop_cnt;
    for (int c = 0; c < NUM_CH; c++)
      if (prune[c] && drop_nxt != '1) drop_nxt = drop_nxt + CNT_W'(1);
    for (int j = 0; j < K; j++) knn_dist[j*DIST_W +: DIST_W] = buf_d[j];
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      done <= 1'b0;
      buf_d <= '{default: '1};
      slot_d <= '{default: '0};
      slot_v <= '0;
      ptr <= '0;
      insert_cnt <= '0;
      drop_cnt <= '0;
    end else if (start) begin
      state <= SEED;
      done <= 1'b0;
    end else if (state == SEED) begin
      state <= RUN;
      buf_d <= seed_srt;
      slot_v <= '0;
      ptr <= '0;
      insert_cnt <= '0;
      drop_cnt <= '0;
    end else if (state == RUN) begin
      for (int c = 0; c < NUM_CH; c++)
        if (ch_valid[c] && !slot_v[c]) begin
          slot_v[c] <= 1'b1;
          slot_d[c] <= ch_dist[c*DIST_W +: DIST_W];
        end else if (prune[c] || (win_v && win == PW'(c))) slot_v[c] <= 1'b0;
      drop_cnt <= drop_nxt;
      if (win_v) begin
        buf_d <= ins_d;
        ptr <= win == PW'(NUM_CH-1) ? '0 : win + PW'(1);
      end
      if (win_v && insert_cnt != '1) insert_cnt <= insert_cnt + CNT_W'(1);
      if (stream_end && slot_v == '0) begin
        state <= DONE;
        done <= 1'b1;
      end
    end

`ifdef TOPK_STORE_IDX_EN
  logic [IDX_W-1:0] buf_i [K];
  logic [IDX_W-1:0] ins_i [K];
  logic [IDX_W-1:0] slot_i [NUM_CH];

  always_comb begin
    for (int j = 0; j < K; j++) ins_i[j] = le[j+1] ? buf_i[j] : le[j] ? slot_i[win] : buf_i[j > 0 ? j-1 : 0];
    for (int j = 0; j < K; j++) knn_idx[j*IDX_W +: IDX_W] = buf_i[j];
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      buf_i <= '{default: '1};
      slot_i <= '{default: '0};
    end else if (!start && state == SEED) buf_i <= '{default: '1};
    else if (!start && state == RUN) begin
      for (int c = 0; c < NUM_CH; c++)
        if (ch_valid[c] && !slot_v[c]) slot_i[c] <= ch_idx[c*IDX_W +: IDX_W];
      if (win_v) buf_i <= ins_i;
    end
`else
  logic unused_idx;
  assign unused_idx = ^ch_idx;
  assign knn_idx = '1;
`endif
endmodule

// File: tb/tb_topk_stream_sorter.sv
// tb_topk_stream_sorter: directed and randomized checks of topk_stream_sorter (K=4, two channels, 16-bit distances).
module tb_topk_stream_sorter;
  localparam int K = 4, NC = 2, DW = 16, IW = 16;
  logic clk = 0, reset = 1, start = 0, stream_end = 0;
  logic [K*DW-1:0] seed_dist = '0;
  logic [NC-1:0] ch_valid = '0;
  logic [NC*DW-1:0] ch_dist = '0;
  logic [NC*IW-1:0] ch_idx = '0;
  logic [NC-1:0] ch_ready, s_ch_ready;
  logic [DW-1:0] threshold, s_threshold;
  logic [K*DW-1:0] knn_dist, s_knn_dist;
  logic [K*IW-1:0] knn_idx, s_knn_idx;
  logic done, s_done;
  logic [15:0] insert_cnt, drop_cnt;
  logic [1:0] s_insert_cnt, s_drop_cnt;
  int total = 0, passed = 0;
  logic [31:0] cq [NC][$];
  logic [15:0] md [$];
  logic [15:0] mi [$];
  bit used [4096];

  topk_stream_sorter #(.K(K), .NUM_CH(NC), .DIST_W(DW), .IDX_W(IW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .seed_dist(seed_dist), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .ch_dist(ch_dist), .ch_idx(ch_idx), .stream_end(stream_end),
    .threshold(threshold), .knn_dist(knn_dist), .knn_idx(knn_idx), .done(done),
    .insert_cnt(insert_cnt), .drop_cnt(drop_cnt));

  topk_stream_sorter #(.K(K), .NUM_CH(NC), .DIST_W(DW), .IDX_W(IW), .CNT_W(2)) sat (
    .clk(clk), .reset(reset), .start(start), .seed_dist(seed_dist), .ch_valid(ch_valid),
    .ch_ready(s_ch_ready), .ch_dist(ch_dist), .ch_idx(ch_idx), .stream_end(stream_end),
    .threshold(s_threshold), .knn_dist(s_knn_dist), .knn_idx(s_knn_idx), .done(s_done),
    .insert_cnt(s_insert_cnt), .drop_cnt(s_drop_cnt));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ix(input logic [63:0] v);
`ifdef TOPK_STORE_IDX_EN
    return v;
`else
    return '1;
`endif
  endfunction

  task automatic do_start();
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
  endtask

  task automatic send(input int c, input logic [15:0] d, input logic [15:0] i);
    ch_dist[c*DW +: DW] = d;
    ch_idx[c*IW +: IW] = i;
    ch_valid[c] = 1;
    for (int n = 0; n < 20 && !ch_ready[c]; n++) @(negedge clk);
    @(negedge clk);
    ch_valid[c] = 0;
    for (int n = 0; n < 20 && !ch_ready[c]; n++) @(negedge clk);
    chk("send_slot_free", 64'(ch_ready[c]), 64'd1);
  endtask

  function automatic logic [15:0] fresh();
    logic [15:0] v;
    do v = 16'($urandom_range(1, 4000)); while (used[v]);
    used[v] = 1;
    return v;
  endfunction

  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(ch_ready), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_dist"}, knn_dist, '1);
    chk({tag, "_idx"}, knn_idx, '1);
    chk({tag, "_thr"}, 64'(threshold), 64'hFFFF);
    chk({tag, "_cnts"}, {32'(insert_cnt), 32'(drop_cnt)}, 64'd0);
  endtask

  initial begin
    seed_dist = {16'd20, 16'd30, 16'd10, 16'd40};
    #1 reset = 0;
    #1 reset_vals("rst");
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    // seed only, then immediate stream_end
    start = 1;
    @(negedge clk);
    start = 0;
    stream_end = 1;
    chk("t1_done_c1", 64'(done), 64'd0);
    @(negedge clk);
    chk("t1_sorted", knn_dist, 64'h0028_001E_0014_000A);
    chk("t1_thr", 64'(threshold), 64'd40);
    chk("t1_done_c2", 64'(done), 64'd0);
    chk("t1_ready_run", 64'(ch_ready), 64'd3);
    @(negedge clk);
    chk("t1_done_c3", 64'(done), 64'd1);
    chk("t1_ready_done", 64'(ch_ready), 64'd0);
    chk("t1_cnts", {32'(insert_cnt), 32'(drop_cnt)}, 64'd0);
    chk("t1_idx", knn_idx, '1);
    stream_end = 0;
    // two inserts on ch0
    do_start();
    ch_dist[15:0] = 16'd25;
    ch_idx[15:0] = 16'd7;
    ch_valid[0] = 1;
    @(negedge clk);
    ch_valid[0] = 0;
    chk("t2_slot_busy", 64'(ch_ready[0]), 64'd0);
    chk("t2_thr_old", 64'(threshold), 64'd40);
    @(negedge clk);
    chk("t2_thr_new", 64'(threshold), 64'd30);
    chk("t2_slot_free", 64'(ch_ready[0]), 64'd1);
    chk("t2_buf1", knn_dist, 64'h001E_0019_0014_000A);
    send(0, 16'd5, 16'd9);
    chk("t2_buf2", knn_dist, 64'h0019_0014_000A_0005);
    chk("t2_idx", knn_idx, ix(64'h0007_FFFF_FFFF_0009));
    chk("t2_thr", 64'(threshold), 64'd25);
    chk("t2_cnts", {32'(insert_cnt), 32'(drop_cnt)}, {32'd2, 32'd0});
    // simultaneous equal candidates
    do_start();
    ch_dist = {16'd15, 16'd15};
    ch_idx = {16'd2, 16'd1};
    ch_valid = 2'b11;
    @(negedge clk);
    ch_valid = 0;
    chk("t3_ready_busy", 64'(ch_ready), 64'd0);
    @(negedge clk);
    chk("t3_first", knn_dist, 64'h001E_0014_000F_000A);
    chk("t3_ready_ch0", 64'(ch_ready), 64'd1);
    chk("t3_ins1", 64'(insert_cnt), 64'd1);
    @(negedge clk);
    chk("t3_second", knn_dist, 64'h0014_000F_000F_000A);
    chk("t3_idx", knn_idx, ix(64'hFFFF_0002_0001_FFFF));
    chk("t3_thr", 64'(threshold), 64'd20);
    chk("t3_ins2", 64'(insert_cnt), 64'd2);
    // candidate equal to threshold is pruned
    do_start();
    send(0, 16'd40, 16'd3);
    chk("t4_drop", 64'(drop_cnt), 64'd1);
    chk("t4_ins", 64'(insert_cnt), 64'd0);
    chk("t4_buf", knn_dist, 64'h0028_001E_0014_000A);
    chk("t4_sat_drop", 64'(s_drop_cnt), 64'd1);
    // held valid waits for its slot, then async reset mid-stream
    do_start();
    send(0, 16'd35, 16'd4);
    ch_dist = {16'd13, 16'd12};
    ch_idx = {16'd6, 16'd5};
    ch_valid = 2'b11;
    @(negedge clk);
    ch_valid = 2'b01;
    chk("t5_ready_busy", 64'(ch_ready), 64'd0);
    @(negedge clk);
    chk("t5_hold_ready", 64'(ch_ready[0]), 64'd0);
    chk("t5_ch1_first", knn_dist, 64'h001E_0014_000D_000A);
    @(negedge clk);
    chk("t5_released", 64'(ch_ready[0]), 64'd1);
    chk("t5_buf", knn_dist, 64'h0014_000D_000C_000A);
    chk("t5_ins", 64'(insert_cnt), 64'd3);
    #2 reset = 0;
    #1 reset_vals("t5_rst");
    ch_valid = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    // saturation on the 2-bit instance
    do_start();
    for (int n = 0; n < 5; n++) send(0, 16'd50, 16'(n));
    chk("t6_drop", 64'(drop_cnt), 64'd5);
    chk("t6_sat_drop", 64'(s_drop_cnt), 64'd3);
    chk("t6_sat_ins", 64'(s_insert_cnt), 64'd0);
    chk("t6_buf", knn_dist, 64'h0028_001E_0014_000A);
    // randomized queries against a sorted-multiset reference
    for (int r = 0; r < 8; r++) begin
      int acc;
      logic [63:0] exp_d, exp_i;
      bit taken [$];
      foreach (used[i]) used[i] = 0;
      md.delete();
      mi.delete();
      acc = 0;
      for (int i = 0; i < K; i++) begin
        logic [15:0] v;
        v = fresh();
        seed_dist[i*DW +: DW] = v;
        md.push_back(v);
        mi.push_back(16'hFFFF);
      end
      for (int i = 0; i < 10; i++) begin
        logic [15:0] v, id;
        v = fresh();
        id = 16'($urandom_range(0, 16'hFFFE));
        cq[$urandom_range(0, NC-1)].push_back({id, v});
        md.push_back(v);
        mi.push_back(id);
      end
      do_start();
      for (int cyc = 0; cyc < 400 && (cq[0].size() > 0 || cq[1].size() > 0); cyc++) begin
        for (int c = 0; c < NC; c++)
          if (cq[c].size() > 0 && $urandom_range(0, 3) != 0) begin
            ch_valid[c] = 1;
            ch_dist[c*DW +: DW] = cq[c][0][15:0];
            ch_idx[c*IW +: IW] = cq[c][0][31:16];
            if (ch_ready[c]) begin
              void'(cq[c].pop_front());
              acc++;
            end
          end else ch_valid[c] = 0;
        @(negedge clk);
      end
      ch_valid = 0;
      chk("rand_drained", 64'(cq[0].size() + cq[1].size()), 64'd0);
      stream_end = 1;
      for (int n = 0; n < 50 && !done; n++) @(negedge clk);
      stream_end = 0;
      chk("rand_done", 64'(done), 64'd1);
      taken = {};
      foreach (md[i]) taken.push_back(0);
      for (int k = 0; k < K; k++) begin
        int best;
        best = -1;
        foreach (md[i])
          if (!taken[i] && (best < 0 || md[i] < md[best])) best = i;
        taken[best] = 1;
        exp_d[k*DW +: DW] = md[best];
        exp_i[k*IW +: IW] = mi[best];
      end
      chk("rand_dist", knn_dist, exp_d);
      chk("rand_idx", knn_idx, ix(exp_i));
      chk("rand_thr", 64'(threshold), 64'(exp_d[63:48]));
      chk("rand_cnt_sum", 64'(insert_cnt) + 64'(drop_cnt), 64'(acc));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
